// File: rtl/alu_issue_stage.sv
//==============================================================================
// Module   : alu_issue_stage
// Brief    : RV32I decode/issue stage; registers ALU control and operands
//            into an ID/EX register behind a valid/ready handshake with flush.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module alu_issue_stage #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [5:0]      ALU_Control,
    output logic            branch_op,
    output logic [XLEN-1:0] operand_A,
    output logic [XLEN-1:0] operand_B,
    output logic [XLEN-1:0] store_data,
    output logic [4:0]      rd_addr,
    output logic            illegal
);

    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;

    localparam logic [5:0] c_ALU_ADD    = 6'b000000;
    localparam logic [5:0] c_ALU_JAL    = 6'b011111;
    localparam logic [5:0] c_ALU_JALR   = 6'b111111;

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_shamt;
    logic [XLEN-1:0] w_pc_plus4;
    logic            w_alt_op;
    logic            w_take;
    logic            w_unused;

    logic [5:0]      w_ctrl;
    logic            w_branch;
    logic [XLEN-1:0] w_op_a;
    logic [XLEN-1:0] w_op_b;
    logic [4:0]      w_rd;
    logic            w_illegal;

    logic            r_valid;
    logic [5:0]      r_ctrl;
    logic            r_branch;
    logic [XLEN-1:0] r_op_a;
    logic [XLEN-1:0] r_op_b;
    logic [XLEN-1:0] r_store;
    logic [4:0]      r_rd;
    logic            r_illegal;

    assign w_opcode   = instruction[6:0];
    assign w_funct3   = instruction[14:12];
    assign w_imm_i    = XLEN'($signed(instruction[31:20]));
    assign w_imm_s    = XLEN'($signed({instruction[31:25], instruction[11:7]}));
    assign w_imm_u    = XLEN'($signed({instruction[31:12], 12'b0}));
    assign w_shamt    = XLEN'(instruction[24:20]);
    assign w_pc_plus4 = pc + XLEN'(4);
    // Register source indices are resolved upstream by the register file.
    assign w_unused   = ^instruction[19:15];

    // instr[30] selects SUB/SRA only; other funct3 values ignore it.
    assign w_alt_op = instruction[30] && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101));

    always_comb begin
        w_ctrl    = c_ALU_ADD;
        w_branch  = 1'b0;
        w_op_a    = '0;
        w_op_b    = '0;
        w_rd      = instruction[11:7];
        w_illegal = 1'b0;
        case (w_opcode)
            c_OPC_OP: begin
                w_ctrl = {2'b00, w_alt_op, w_funct3};
                w_op_a = rs1_data;
                w_op_b = rs2_data;
            end
            c_OPC_OP_IMM: begin
                w_ctrl = {2'b00, (w_funct3 == 3'b101) && instruction[30], w_funct3};
                w_op_a = rs1_data;
                w_op_b = (w_funct3[1:0] == 2'b01) ? w_shamt : w_imm_i;
            end
            c_OPC_BRANCH: begin
                w_ctrl    = {3'b010, w_funct3};
                w_branch  = 1'b1;
                w_op_a    = rs1_data;
                w_op_b    = rs2_data;
                w_rd      = 5'd0;
                w_illegal = (w_funct3 == 3'b010) || (w_funct3 == 3'b011);
            end
            c_OPC_LOAD: begin
                w_op_a = rs1_data;
                w_op_b = w_imm_i;
            end
            c_OPC_STORE: begin
                w_op_a = rs1_data;
                w_op_b = w_imm_s;
                w_rd   = 5'd0;
            end
            c_OPC_LUI: begin
                w_op_b = w_imm_u;
            end
            c_OPC_AUIPC: begin
                w_op_a = pc;
                w_op_b = w_imm_u;
            end
            c_OPC_JAL: begin
                w_ctrl = c_ALU_JAL;
                w_op_a = w_pc_plus4;
            end
            c_OPC_JALR: begin
                w_ctrl = c_ALU_JALR;
                w_op_a = w_pc_plus4;
            end
            default: begin
                w_illegal = 1'b1;
                w_rd      = 5'd0;
            end
        endcase
    end

    assign in_ready = !r_valid || out_ready;
    assign w_take   = in_valid && in_ready;

    // Flush outranks both capture and hold.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_ctrl    <= '0;
            r_branch  <= 1'b0;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_store   <= '0;
            r_rd      <= '0;
            r_illegal <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_take) begin
            r_valid   <= 1'b1;
            r_ctrl    <= w_ctrl;
            r_branch  <= w_branch;
            r_op_a    <= w_op_a;
            r_op_b    <= w_op_b;
            r_store   <= rs2_data;
            r_rd      <= w_rd;
            r_illegal <= w_illegal;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid   = r_valid;
    assign ALU_Control = r_ctrl;
    assign branch_op   = r_branch;
    assign operand_A   = r_op_a;
    assign operand_B   = r_op_b;
    assign store_data  = r_store;
    assign rd_addr     = r_rd;
    assign illegal     = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
//==============================================================================
// Module   : tb_alu_issue_stage
// Brief    : Directed plus randomized checks of alu_issue_stage against an
//            instruction-level reference model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_alu_issue_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        out_ready;
    logic        out_valid;
    logic [5:0]  ALU_Control;
    logic        branch_op;
    logic [31:0] operand_A;
    logic [31:0] operand_B;
    logic [31:0] store_data;
    logic [4:0]  rd_addr;
    logic        illegal;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [5:0]  ctrl;
        logic        br;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic        ill;
    } op_t;

    op_t  exp_op;
    logic exp_valid;

    alu_issue_stage #(.XLEN(32)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instruction (instruction),
        .pc          (pc),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .flush       (flush),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .ALU_Control (ALU_Control),
        .branch_op   (branch_op),
        .operand_A   (operand_A),
        .operand_B   (operand_B),
        .store_data  (store_data),
        .rd_addr     (rd_addr),
        .illegal     (illegal)
    );

    always #5 clock = ~clock;

    // Instruction-level meaning of each RV32I format, independent of the stage.
    function automatic op_t model(input logic [31:0] ins, input logic [31:0] p,
                                  input logic [31:0] r1, input logic [31:0] r2);
        op_t         o;
        logic [2:0]  f3;
        logic [31:0] imm_i, imm_s, imm_u;
        f3    = ins[14:12];
        imm_i = {{20{ins[31]}}, ins[31:20]};
        imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        imm_u = {ins[31:12], 12'h000};
        o     = '0;
        o.sd  = r2;
        o.rd  = ins[11:7];
        case (ins[6:0])
            7'h33: begin
                o.a = r1; o.b = r2; o.ctrl = {3'b000, f3};
                if (ins[30] && (f3 == 3'd0 || f3 == 3'd5)) o.ctrl = o.ctrl + 6'd8;
            end
            7'h13: begin
                o.a = r1; o.ctrl = {3'b000, f3};
                o.b = (f3 == 3'd1 || f3 == 3'd5) ? {27'd0, ins[24:20]} : imm_i;
                if (f3 == 3'd5 && ins[30]) o.ctrl = 6'd13;
            end
            7'h63: begin
                o.a = r1; o.b = r2; o.br = 1'b1; o.rd = 5'd0;
                o.ctrl = 6'd16 + {3'b000, f3};
                o.ill  = (f3 == 3'd2 || f3 == 3'd3);
            end
            7'h03: begin o.a = r1; o.b = imm_i; end
            7'h23: begin o.a = r1; o.b = imm_s; o.rd = 5'd0; end
            7'h37: o.b = imm_u;
            7'h17: begin o.a = p; o.b = imm_u; end
            7'h6F: begin o.ctrl = 6'd31; o.a = p + 32'd4; end
            7'h67: begin o.ctrl = 6'd63; o.a = p + 32'd4; end
            default: begin o.ill = 1'b1; o.rd = 5'd0; end
        endcase
        return o;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic chk_outputs();
        chk("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
        if (exp_valid) begin
            chk("ALU_Control", {26'd0, ALU_Control}, {26'd0, exp_op.ctrl});
            chk("branch_op",   {31'd0, branch_op},   {31'd0, exp_op.br});
            chk("operand_A",   operand_A,            exp_op.a);
            chk("operand_B",   operand_B,            exp_op.b);
            chk("store_data",  store_data,           exp_op.sd);
            chk("rd_addr",     {27'd0, rd_addr},     {27'd0, exp_op.rd});
            chk("illegal",     {31'd0, illegal},     {31'd0, exp_op.ill});
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] p,
                         input logic [31:0] r1, input logic [31:0] r2,
                         input logic ordy, input logic fl);
        in_valid = v; instruction = ins; pc = p;
        rs1_data = r1; rs2_data = r2; out_ready = ordy; flush = fl;
    endtask

    // One clock of the handshake, applied to the reference state.
    task automatic step();
        op_t  nxt;
        logic take;
        #1;
        chk("in_ready", {31'd0, in_ready}, {31'd0, (!exp_valid || out_ready)});
        nxt  = model(instruction, pc, rs1_data, rs2_data);
        take = in_valid && (!exp_valid || out_ready);
        @(posedge clock);
        #1;
        if (flush)          exp_valid = 1'b0;
        else if (take)      begin exp_valid = 1'b1; exp_op = nxt; end
        else if (out_ready) exp_valid = 1'b0;
        chk_outputs();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_ctrl"},  {26'd0, ALU_Control}, 32'd0);
        chk({tag, "_br"},    {31'd0, branch_op}, 32'd0);
        chk({tag, "_A"},     operand_A, 32'd0);
        chk({tag, "_B"},     operand_B, 32'd0);
        chk({tag, "_sd"},    store_data, 32'd0);
        chk({tag, "_rd"},    {27'd0, rd_addr}, 32'd0);
        chk({tag, "_ill"},   {31'd0, illegal}, 32'd0);
    endtask

    logic [6:0] opcs [0:9];
    logic [31:0] rins;

    initial begin
        opcs = '{7'h33, 7'h13, 7'h63, 7'h03, 7'h23, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h7F};
        exp_valid = 1'b0;
        exp_op    = '0;
        reset     = 1'b1;
        drive(0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0);
        #1;
        chk_all_zero("rst_init");
        @(posedge clock); #1;
        reset = 1'b0;

        // ADDI x1, x0, 5
        drive(1, 32'h00500093, 32'h0, 32'd7, 32'h0, 1, 0);
        step();
        chk("addi_ctrl", {26'd0, ALU_Control}, 32'h0);
        chk("addi_A", operand_A, 32'd7);
        chk("addi_B", operand_B, 32'd5);
        chk("addi_rd", {27'd0, rd_addr}, 32'd1);

        // SUB then SRAI back-to-back
        drive(1, 32'h402081B3, 32'h0, 32'd10, -32'sd5, 1, 0);
        step();
        chk("sub_ctrl", {26'd0, ALU_Control}, 32'h08);
        chk("sub_B", operand_B, 32'hFFFFFFFB);
        drive(1, 32'h40335293, 32'h0, -32'sd10, 32'h0, 1, 0);
        step();
        chk("srai_ctrl", {26'd0, ALU_Control}, 32'h0D);
        chk("srai_A", operand_A, 32'hFFFFFFF6);
        chk("srai_B", operand_B, 32'd3);

        // BEQ, JAL, JAL with wrapping pc
        drive(1, 32'h00208463, 32'h40, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0);
        step();
        chk("beq_ctrl", {26'd0, ALU_Control}, 32'h10);
        chk("beq_br", {31'd0, branch_op}, 32'd1);
        chk("beq_rd", {27'd0, rd_addr}, 32'd0);
        drive(1, 32'h010000EF, 32'h100, 32'h0, 32'h0, 1, 0);
        step();
        chk("jal_ctrl", {26'd0, ALU_Control}, 32'h1F);
        chk("jal_A", operand_A, 32'h104);
        chk("jal_B", operand_B, 32'h0);
        drive(1, 32'h010000EF, 32'hFFFFFFFC, 32'h0, 32'h0, 1, 0);
        step();
        chk("jal_wrap_A", operand_A, 32'h0);

        // Backpressure: ADDI held 3 cycles while LUI waits
        drive(1, 32'h00500093, 32'h0, 32'd7, 32'h0, 1, 0);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h123452B7, 32'h0, 32'h0, 32'h0, 0, 0);
            step();
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
            chk("hold_A", operand_A, 32'd7);
        end
        drive(1, 32'h123452B7, 32'h0, 32'h0, 32'h0, 1, 0);
        step();
        chk("lui_A", operand_A, 32'h0);
        chk("lui_B", operand_B, 32'h12345000);
        drive(0, 32'h123452B7, 32'h0, 32'h0, 32'h0, 1, 0);
        step();
        chk("no_dup_valid", {31'd0, out_valid}, 32'd0);

        // Flush beats capture, then an illegal opcode
        drive(1, 32'h00500093, 32'h0, 32'd7, 32'h0, 1, 1);
        step();
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        drive(1, 32'h0000007F, 32'h0, 32'h55, 32'h66, 1, 0);
        step();
        chk("ill_flag", {31'd0, illegal}, 32'd1);
        chk("ill_ctrl", {26'd0, ALU_Control}, 32'h0);
        chk("ill_A", operand_A, 32'h0);
        chk("ill_B", operand_B, 32'h0);

        // Asynchronous reset while holding
        drive(1, 32'h00500093, 32'h0, 32'd7, 32'h0, 1, 0);
        step();
        drive(0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0);
        step();
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("rst_hold");
        exp_valid = 1'b0;
        exp_op    = '0;
        @(posedge clock); #1;
        reset = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rins = $urandom;
            rins[6:0] = opcs[$urandom_range(0, 9)];
            drive(($urandom_range(0, 3) != 0), rins,
                  ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : $urandom,
                  $urandom, $urandom,
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
